// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Brief    : 2**DEPTH_LOG2 x WIDTH register file with two combinational read
//            ports, one synchronous write port, a zero flag and a write counter.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      IN,
    input  logic [DEPTH_LOG2-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [DEPTH_LOG2-1:0] OUT1ADDRESS,
    input  logic [DEPTH_LOG2-1:0] OUT2ADDRESS,
    output logic [WIDTH-1:0]      OUT1,
    output logic [WIDTH-1:0]      OUT2,
    input  logic                  ZERO_IN,
    input  logic                  FLAG_WRITE,
    output logic                  ZERO_FLAG,
    output logic [7:0]            WRITE_COUNT
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] r_regs [c_DEPTH];
    logic             r_zero_flag;
    logic [7:0]       r_write_count;
    logic             w_wr_en;

    // Reset dominates every other update on the same edge.
    assign w_wr_en = WRITE && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_write_count <= 8'd0;
        end else if (WRITE) begin
            r_regs[INADDRESS] <= IN;
            r_write_count     <= r_write_count + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_zero_flag <= 1'b0;
        end else if (FLAG_WRITE) begin
            r_zero_flag <= ZERO_IN;
        end
    end

    generate
        if (BYPASS) begin : g_bypass
            // Forward the pending write so a same-cycle reader sees IN.
            assign OUT1 = (w_wr_en && (OUT1ADDRESS == INADDRESS)) ? IN : r_regs[OUT1ADDRESS];
            assign OUT2 = (w_wr_en && (OUT2ADDRESS == INADDRESS)) ? IN : r_regs[OUT2ADDRESS];
        end else begin : g_no_bypass
            assign OUT1 = r_regs[OUT1ADDRESS];
            assign OUT2 = r_regs[OUT2ADDRESS];
        end
    endgenerate

    assign ZERO_FLAG   = r_zero_flag;
    assign WRITE_COUNT = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Brief    : Self-checking bench for reg_file using a write scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int c_WIDTH  = 8;
    localparam int c_ALOG2  = 3;
    localparam bit c_BYPASS = 1'b0;

    typedef struct {
        logic [c_ALOG2-1:0] addr;
        logic [c_WIDTH-1:0] data;
    } wr_item_t;

    logic               clk;
    logic               rst;
    logic [c_WIDTH-1:0] in_data;
    logic [c_ALOG2-1:0] in_addr;
    logic               wr;
    logic [c_ALOG2-1:0] rd1_addr;
    logic [c_ALOG2-1:0] rd2_addr;
    logic [c_WIDTH-1:0] out1;
    logic [c_WIDTH-1:0] out2;
    logic               zero_in;
    logic               flag_wr;
    logic               zero_flag;
    logic [7:0]         write_count;

    wr_item_t     sb_q[$];
    logic [7:0]   model_regs [8];
    logic [7:0]   model_count;
    int           n_checks;
    int           n_fail;

    reg_file #(
        .WIDTH      (c_WIDTH),
        .DEPTH_LOG2 (c_ALOG2),
        .BYPASS     (c_BYPASS)
    ) u_dut (
        .CLK         (clk),
        .RESET       (rst),
        .IN          (in_data),
        .INADDRESS   (in_addr),
        .WRITE       (wr),
        .OUT1ADDRESS (rd1_addr),
        .OUT2ADDRESS (rd2_addr),
        .OUT1        (out1),
        .OUT2        (out2),
        .ZERO_IN     (zero_in),
        .FLAG_WRITE  (flag_wr),
        .ZERO_FLAG   (zero_flag),
        .WRITE_COUNT (write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        model_count = 8'd0;
    endtask

    // Drive one write for a single edge and record the expected result.
    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wr_item_t it;
        in_addr = a;
        in_data = d;
        wr      = 1'b1;
        it.addr = a;
        it.data = d;
        sb_q.push_back(it);
        tick();
        wr = 1'b0;
        model_regs[a] = d;
        model_count   = model_count + 8'd1;
    endtask

    task automatic test_reset();
        wr_item_t it;
        zero_in = 1'b1; flag_wr = 1'b1;
        do_write(3'd3, 8'hAA);
        flag_wr = 1'b0; zero_in = 1'b0;
        it = sb_q.pop_front();
        rd1_addr = it.addr; #1;
        n_checks++;
        if (out1 !== it.data) begin
            n_fail++; $display("FAIL reset_prewrite: OUT1=%h expected %h", out1, it.data);
        end
        do_reset();
        rd1_addr = 3'd3; #1;
        n_checks++;
        if (out1 !== 8'h00) begin
            n_fail++; $display("FAIL reset_r3: OUT1=%h expected 00", out1);
        end
        n_checks++;
        if (zero_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_flag: ZERO_FLAG=%b expected 0", zero_flag);
        end
        n_checks++;
        if (write_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count: WRITE_COUNT=%0d expected 0", write_count);
        end
        for (int a = 0; a < 8; a++) begin
            rd1_addr = 3'(a); rd2_addr = 3'(7 - a); #1;
            n_checks++;
            if (out1 !== 8'h00 || out2 !== 8'h00) begin
                n_fail++; $display("FAIL reset_all_zero: addr %0d OUT1=%h OUT2=%h expected 00", a, out1, out2);
            end
        end
    endtask

    task automatic test_write_read_all();
        wr_item_t it;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 8'(8'h10 + i));
            it = sb_q.pop_front();
            rd2_addr = it.addr; #1;
            n_checks++;
            if (out2 !== it.data) begin
                n_fail++; $display("FAIL write_visible: r%0d OUT2=%h expected %h", it.addr, out2, it.data);
            end
        end
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                rd1_addr = 3'(a); rd2_addr = 3'(b); #1;
                n_checks++;
                if (out1 !== model_regs[a] || out2 !== model_regs[b]) begin
                    n_fail++;
                    $display("FAIL read_pair: (%0d,%0d) got %h,%h expected %h,%h",
                             a, b, out1, out2, model_regs[a], model_regs[b]);
                end
            end
        end
        n_checks++;
        if (write_count !== 8'd8) begin
            n_fail++; $display("FAIL count_8: WRITE_COUNT=%0d expected 8", write_count);
        end
    endtask

    task automatic test_hold();
        wr_item_t it;
        do_write(3'd5, 8'h33);
        it = sb_q.pop_front();
        in_data = 8'hFF; in_addr = 3'd5; wr = 1'b0;
        repeat (3) tick();
        rd1_addr = it.addr; #1;
        n_checks++;
        if (out1 !== it.data) begin
            n_fail++; $display("FAIL hold_r5: OUT1=%h expected %h", out1, it.data);
        end
        n_checks++;
        if (write_count !== model_count) begin
            n_fail++; $display("FAIL hold_count: WRITE_COUNT=%0d expected %0d", write_count, model_count);
        end
    endtask

    task automatic test_read_during_write();
        wr_item_t it;
        logic [7:0] exp_pre;
        do_write(3'd2, 8'h01);
        void'(sb_q.pop_front());
        in_data = 8'h7E; in_addr = 3'd2; wr = 1'b1;
        rd1_addr = 3'd2; rd2_addr = 3'd2;
        it.addr = 3'd2; it.data = 8'h7E;
        sb_q.push_back(it);
        #1;
        exp_pre = c_BYPASS ? 8'h7E : 8'h01;
        n_checks++;
        if (out1 !== exp_pre || out2 !== exp_pre) begin
            n_fail++; $display("FAIL rdw_before: OUT1=%h OUT2=%h expected %h", out1, out2, exp_pre);
        end
        tick();
        wr = 1'b0;
        model_regs[2] = 8'h7E;
        model_count   = model_count + 8'd1;
        it = sb_q.pop_front();
        n_checks++;
        if (out1 !== it.data || out2 !== it.data) begin
            n_fail++; $display("FAIL rdw_after: OUT1=%h OUT2=%h expected %h", out1, out2, it.data);
        end
    endtask

    task automatic test_reset_collision();
        do_write(3'd4, 8'h99);
        void'(sb_q.pop_front());
        zero_in = 1'b1; flag_wr = 1'b1; tick();
        rst = 1'b1; wr = 1'b1; in_data = 8'h55; in_addr = 3'd4;
        rd1_addr = 3'd4; #1;
        if (c_BYPASS) begin
            n_checks++;
            if (out1 !== 8'h99) begin
                n_fail++; $display("FAIL coll_no_bypass: OUT1=%h expected 99", out1);
            end
        end
        tick();
        rst = 1'b0; wr = 1'b0; flag_wr = 1'b0; zero_in = 1'b0; #1;
        n_checks++;
        if (out1 !== 8'h00) begin
            n_fail++; $display("FAIL coll_r4: OUT1=%h expected 00", out1);
        end
        n_checks++;
        if (zero_flag !== 1'b0) begin
            n_fail++; $display("FAIL coll_flag: ZERO_FLAG=%b expected 0", zero_flag);
        end
        n_checks++;
        if (write_count !== 8'd0) begin
            n_fail++; $display("FAIL coll_count: WRITE_COUNT=%0d expected 0", write_count);
        end
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        model_count = 8'd0;
    endtask

    task automatic test_flag();
        wr = 1'b0;
        zero_in = 1'b1; flag_wr = 1'b1; tick();
        n_checks++;
        if (zero_flag !== 1'b1) begin
            n_fail++; $display("FAIL flag_set: ZERO_FLAG=%b expected 1", zero_flag);
        end
        zero_in = 1'b0; flag_wr = 1'b0; tick();
        n_checks++;
        if (zero_flag !== 1'b1) begin
            n_fail++; $display("FAIL flag_hold: ZERO_FLAG=%b expected 1", zero_flag);
        end
        flag_wr = 1'b1; tick();
        flag_wr = 1'b0;
        n_checks++;
        if (zero_flag !== 1'b0) begin
            n_fail++; $display("FAIL flag_clear: ZERO_FLAG=%b expected 0", zero_flag);
        end
        n_checks++;
        if (write_count !== model_count) begin
            n_fail++; $display("FAIL flag_no_write: WRITE_COUNT=%0d expected %0d", write_count, model_count);
        end
    endtask

    task automatic test_count_wrap();
        wr_item_t it;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            do_write(3'(i), 8'(i ^ 8'h5A));
            it = sb_q.pop_front();
            if (i == 254) begin
                n_checks++;
                if (write_count !== 8'd255) begin
                    n_fail++; $display("FAIL count_255: WRITE_COUNT=%0d expected 255", write_count);
                end
            end
        end
        n_checks++;
        if (write_count !== 8'd0 || write_count !== model_count) begin
            n_fail++; $display("FAIL count_wrap: WRITE_COUNT=%0d expected 0", write_count);
        end
        rd1_addr = it.addr; #1;
        n_checks++;
        if (out1 !== it.data) begin
            n_fail++; $display("FAIL wrap_last_data: OUT1=%h expected %h", out1, it.data);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; wr = 1'b0; in_data = '0; in_addr = '0;
        rd1_addr = '0; rd2_addr = '0; zero_in = 1'b0; flag_wr = 1'b0;
        model_count = 8'd0;
        for (int i = 0; i < 8; i++) model_regs[i] = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        test_reset();
        test_write_read_all();
        test_hold();
        test_read_during_write();
        test_flag();
        test_reset_collision();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
